// File: rtl/uvmt_cv32e40x_sl_obi_fifo_ctrl.sv
// OBI handshake -> outstanding-transaction FIFO controller.
// Tracks the outstanding count and state, and flags protocol violations that would corrupt the FIFO.
package uvmt_cv32e40x_sl_obi_fifo_ctrl_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic        dbg;
    } obi_inst_req_t;
endpackage

module uvmt_cv32e40x_sl_obi_fifo_ctrl
    import uvmt_cv32e40x_sl_obi_fifo_ctrl_pkg::*;
#(
    parameter type FIFO_TYPE_T = obi_inst_req_t,
    parameter int  FIFO_SIZE   = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           obi_req,
    input  logic                           obi_gnt,
    input  logic                           obi_rvalid,
    input  FIFO_TYPE_T                     obi_payload,
    output logic                           add_item,
    output logic                           shift_fifo,
    output FIFO_TYPE_T                     item_in,
    output logic [$clog2(FIFO_SIZE+1)-1:0] outstanding,
    output logic                           fifo_empty,
    output logic                           fifo_full,
    output logic                           resp_match,
    output logic                           err_overflow,
    output logic                           err_underflow,
    output logic                           err_req_drop,
    output logic                           err_req_unstable
);
    localparam int CW = $clog2(FIFO_SIZE+1);

    typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt_nxt;
    logic           accept, retire;
    logic           pend;
    FIFO_TYPE_T     pend_payload;

    // A response only retires when something is outstanding; a same-cycle accept can't be answered yet.
    assign accept     = obi_req && obi_gnt;
    assign retire     = obi_rvalid && (outstanding != '0);
    assign add_item   = accept && !(fifo_full && !retire);
    assign shift_fifo = retire;
    assign resp_match = retire;
    assign item_in    = obi_payload;
    assign fifo_empty = (state == S_EMPTY);
    assign fifo_full  = (state == S_FULL);

    always_comb begin
        cnt_nxt   = outstanding;
        state_nxt = S_ACTIVE;
        if (add_item && !retire)
            cnt_nxt = outstanding + 1'b1;
        else if (retire && !add_item)
            cnt_nxt = outstanding - 1'b1;
        if (cnt_nxt == '0)
            state_nxt = S_EMPTY;
        else if (cnt_nxt == CW'(FIFO_SIZE))
            state_nxt = S_FULL;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_EMPTY;
            outstanding <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend         <= 1'b0;
            pend_payload <= '0;
        end else if (obi_req && !obi_gnt) begin
            pend         <= 1'b1;
            pend_payload <= obi_payload;
        end else begin
            pend         <= 1'b0;
        end
    end

    // Sticky diagnostics; they never feed back into the control outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_overflow     <= 1'b0;
            err_underflow    <= 1'b0;
            err_req_drop     <= 1'b0;
            err_req_unstable <= 1'b0;
        end else begin
            if (accept && fifo_full && !retire)
                err_overflow <= 1'b1;
            if (obi_rvalid && (outstanding == '0))
                err_underflow <= 1'b1;
            if (pend && !obi_req)
                err_req_drop <= 1'b1;
            if (pend && obi_req && (obi_payload != pend_payload))
                err_req_unstable <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uvmt_cv32e40x_sl_obi_fifo_ctrl.sv
// Directed + random bench for the OBI FIFO controller.
// Reference model: a payload queue plus sticky flags.
module tb_uvmt_cv32e40x_sl_obi_fifo_ctrl;
    import uvmt_cv32e40x_sl_obi_fifo_ctrl_pkg::*;

    localparam int SZ = 2;
    localparam int CW = $clog2(SZ+1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          obi_req, obi_gnt, obi_rvalid;
    obi_inst_req_t obi_payload, item_in;
    logic          add_item, shift_fifo, fifo_empty, fifo_full, resp_match;
    logic          err_overflow, err_underflow, err_req_drop, err_req_unstable;
    logic [CW-1:0] outstanding;

    uvmt_cv32e40x_sl_obi_fifo_ctrl #(.FIFO_TYPE_T(obi_inst_req_t), .FIFO_SIZE(SZ)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .obi_req(obi_req), .obi_gnt(obi_gnt),
        .obi_rvalid(obi_rvalid), .obi_payload(obi_payload), .add_item(add_item),
        .shift_fifo(shift_fifo), .item_in(item_in), .outstanding(outstanding),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .resp_match(resp_match),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .err_req_drop(err_req_drop), .err_req_unstable(err_req_unstable)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    obi_inst_req_t q[$];
    bit            m_pend;
    obi_inst_req_t m_pp;
    bit            e_ovf, e_und, e_drop, e_uns;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend = 0; m_pp = '0;
        e_ovf = 0; e_und = 0; e_drop = 0; e_uns = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".cnt"},   64'(outstanding),      64'(q.size()));
        chk({tag, ".empty"}, 64'(fifo_empty),       64'(q.size() == 0));
        chk({tag, ".full"},  64'(fifo_full),        64'(q.size() == SZ));
        chk({tag, ".ovf"},   64'(err_overflow),     64'(e_ovf));
        chk({tag, ".und"},   64'(err_underflow),    64'(e_und));
        chk({tag, ".drop"},  64'(err_req_drop),     64'(e_drop));
        chk({tag, ".uns"},   64'(err_req_unstable), 64'(e_uns));
    endtask

    // One cycle: drive, check combinational outputs, advance model, check registered state.
    task automatic step(input string tag, input logic rq, input logic gt, input logic rv,
                        input obi_inst_req_t pl);
        bit acc, ret, add;
        obi_req = rq; obi_gnt = gt; obi_rvalid = rv; obi_payload = pl;
        #1;
        acc = rq && gt;
        ret = rv && (q.size() != 0);
        add = acc && !(q.size() == SZ && !ret);
        chk({tag, ".add"},   64'(add_item),   64'(add));
        chk({tag, ".shift"}, 64'(shift_fifo), 64'(ret));
        chk({tag, ".match"}, 64'(resp_match), 64'(ret));
        chk({tag, ".item"},  64'(item_in),    64'(pl));
        if (rv && q.size() == 0) e_und = 1;
        if (acc && q.size() == SZ && !ret) e_ovf = 1;
        if (m_pend && !rq) e_drop = 1;
        if (m_pend && rq && pl != m_pp) e_uns = 1;
        m_pend = rq && !gt;
        if (m_pend) m_pp = pl;
        if (ret) void'(q.pop_front());
        if (add) q.push_back(pl);
        @(posedge clk_i); #1;
        check_regs(tag);
    endtask

    function automatic obi_inst_req_t rnd_pl();
        obi_inst_req_t p;
        p.addr = $urandom;
        p.prot = 3'($urandom);
        p.dbg  = 1'($urandom);
        return p;
    endfunction

    initial begin
        obi_inst_req_t pa, pb, z;
        bit rq, gt, rv;
        z = '0;
        pa = rnd_pl();
        pb = rnd_pl();
        rst_ni = 1'b0; obi_req = 0; obi_gnt = 0; obi_rvalid = 0; obi_payload = '0;
        model_reset();
        #12;
        check_regs("reset");
        chk("reset.add", 64'(add_item), 64'(0));
        chk("reset.shift", 64'(shift_fifo), 64'(0));
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // single transaction
        step("single.idle", 0, 0, 0, z);
        step("single.acc",  1, 1, 0, pa);
        step("single.wait", 0, 0, 0, z);
        step("single.rsp",  0, 0, 1, z);
        chk("single.empty", 64'(fifo_empty), 64'(1));

        // fill, then simultaneous accept + response
        step("fill.a1", 1, 1, 0, pa);
        step("fill.a2", 1, 1, 0, pb);
        chk("fill.full", 64'(fifo_full), 64'(1));
        step("fill.both", 1, 1, 1, rnd_pl());
        chk("fill.cnt2", 64'(outstanding), 64'(2));
        chk("fill.noovf", 64'(err_overflow), 64'(0));

        // overflow
        step("ovf.acc", 1, 1, 0, rnd_pl());
        chk("ovf.flag", 64'(err_overflow), 64'(1));
        step("ovf.d1", 0, 0, 1, z);
        step("ovf.d2", 0, 0, 1, z);

        // underflow with same-cycle accept
        step("und.both", 1, 1, 1, pa);
        chk("und.flag", 64'(err_underflow), 64'(1));
        chk("und.cnt", 64'(outstanding), 64'(1));
        step("und.drain", 0, 0, 1, z);

        // handshake violations
        step("hs.w1", 1, 0, 0, pa);
        step("hs.w2", 1, 0, 0, pb);
        chk("hs.uns", 64'(err_req_unstable), 64'(1));
        step("hs.drop", 0, 0, 0, z);
        chk("hs.dropflag", 64'(err_req_drop), 64'(1));
        chk("hs.cnt", 64'(outstanding), 64'(0));

        // async reset mid-operation
        step("rst.a1", 1, 1, 0, pa);
        step("rst.a2", 1, 1, 0, pb);
        obi_req = 0; obi_gnt = 0; obi_payload = '0;
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_regs("rst.async");
        chk("rst.add", 64'(add_item), 64'(0));
        #2;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        step("rst.acc", 1, 1, 0, pa);
        chk("rst.cnt1", 64'(outstanding), 64'(1));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rq = $urandom_range(0, 3) != 0;
            gt = $urandom_range(0, 1) == 1;
            rv = $urandom_range(0, 2) == 0;
            step("rnd", rq, gt, rv, (m_pend && $urandom_range(0, 7) != 0) ? m_pp : rnd_pl());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uvmt_cv32e40x_sl_obi_fifo_ctrl.md
# uvmt_cv32e40x_sl_obi_fifo_ctrl

Support-logic controller that drives an outstanding-transaction FIFO from one OBI interface (instruction or data side). It turns the raw OBI handshake (req/gnt address phase, rvalid response phase) into the FIFO's `add_item`/`shift_fifo` controls and keeps an outstanding-transaction count with a FIFO state machine. It flags OBI protocol violations that would corrupt the FIFO. Assertion and coverage code uses its outputs to pair every response with its originating request.

## Interface
- `FIFO_TYPE_T`, default `obi_inst_req_t`: request payload type captured per accepted transaction.
- `FIFO_SIZE`, default 2: maximum outstanding transactions. Must be ≥1.
- `clk_i` in, 1: clock. All state updates on the rising edge.
- `rst_ni` in, 1: asynchronous active-low reset.
- `obi_req` in, 1: OBI address-phase request.
- `obi_gnt` in, 1: OBI address-phase grant.
- `obi_rvalid` in, 1: OBI response valid.
- `obi_payload` in, FIFO_TYPE_T: request payload (addr/we/be/...) presented with `obi_req`.
- `add_item` out, 1: to FIFO; capture `item_in` this cycle.
- `shift_fifo` out, 1: to FIFO; retire the oldest entry this cycle.
- `item_in` out, FIFO_TYPE_T: to FIFO; equals `obi_payload`.
- `outstanding` out, `$clog2(FIFO_SIZE+1)`: registered count of accepted, unanswered requests.
- `fifo_empty` out, 1: registered, `outstanding == 0`.
- `fifo_full` out, 1: registered, `outstanding == FIFO_SIZE`.
- `resp_match` out, 1: `obi_rvalid` and a legal shift this cycle. FIFO `item_out` is the matching request.
- `err_overflow` out, 1: sticky. Accept attempted while full with no simultaneous retire.
- `err_underflow` out, 1: sticky. `obi_rvalid` with `outstanding == 0`.
- `err_req_drop` out, 1: sticky. `obi_req` deasserted before `obi_gnt`.
- `err_req_unstable` out, 1: sticky. `obi_payload` changed while `obi_req` waited for `obi_gnt`.

## Operation
- `accept = obi_req && obi_gnt`. `retire = obi_rvalid && (outstanding != 0)`. Both are combinational.
- `add_item = accept && !(fifo_full && !retire)`. An overflowing accept is suppressed and the FIFO is not written.
- `shift_fifo = retire`. A response with nothing outstanding never shifts. This holds even when an accept occurs in the same cycle, because OBI forbids a same-cycle response to that accept.
- Count update (registered):
  - add only: +1
  - retire only: −1
  - both: unchanged
  - suppressed add: unchanged
  - The count never wraps and never exceeds FIFO_SIZE.
- State machine, encoded as {EMPTY, ACTIVE, FULL} and derived from the next count:
  - EMPTY → ACTIVE on add. When FIFO_SIZE=1, EMPTY → FULL directly.
  - ACTIVE → FULL when the count reaches FIFO_SIZE.
  - ACTIVE → EMPTY when the count reaches 0.
  - FULL → ACTIVE on retire without add. FULL stays FULL on simultaneous add+retire.
  - `fifo_empty` = (state==EMPTY). `fifo_full` = (state==FULL).
- Pending-request tracking:
  - A 1-bit `pend` register is set when `obi_req && !obi_gnt`.
  - `pend` also latches `obi_payload` into `pend_payload`.
  - `pend` clears on `obi_gnt`, or on `!obi_req`, which also triggers the drop error.
- Error detection:
  - `err_req_drop` sets when `pend && !obi_req`.
  - `err_req_unstable` sets when `pend && obi_req && obi_payload != pend_payload`.
  - `err_overflow` sets when `accept && fifo_full && !retire`.
  - `err_underflow` sets when `obi_rvalid && outstanding == 0`.
  - Every error flag is sticky until reset and has no further side effect on control outputs.
- `resp_match = retire`.

## Timing
- Reset values:
  - `outstanding` = 0 and state = EMPTY, so `fifo_empty` = 1 and `fifo_full` = 0.
  - All `err_*` flags = 0, `pend` = 0, `pend_payload` = '0.
  - `add_item`, `shift_fifo` and `resp_match` are 0 whenever inputs are 0.
- `add_item`, `shift_fifo`, `item_in` and `resp_match` are combinational with zero latency. The FIFO registers them on the same edge that this block updates `outstanding`.
- `outstanding`, `fifo_empty`, `fifo_full` and the error flags reflect an event one cycle after the event cycle.
- An error flag is visible the cycle after the violating cycle. It has no combinational error path.
- Reset asserted mid-operation clears everything immediately, regardless of the clock. The paired FIFO is reset by the same `rst_ni`.
- A response may not be matched in the same cycle as its own accept. The earliest legal `resp_match` is one cycle after `add_item`.

## Test plan
- **Single transaction.** FIFO_SIZE=2. req+gnt at cycle 1 with payload A, rvalid at cycle 3.
  - Response: `add_item` at 1. `outstanding`=1 at cycles 2–3.
  - `shift_fifo`/`resp_match` at 3. `outstanding`=0 and `fifo_empty`=1 at 4. No errors.
- **Fill and simultaneous events.** Accept at cycles 1 and 2, then at cycle 3 accept + rvalid.
  - Response: `fifo_full`=1 at 3. At cycle 3 `add_item`=1 and `shift_fifo`=1.
  - `outstanding` stays 2 and `fifo_full` stays 1 at 4. No overflow.
- **Overflow.** Full with count 2, then accept with no rvalid.
  - Response: `add_item`=0 and `err_overflow`=1 next cycle. `outstanding` stays 2.
- **Underflow.** Empty, then rvalid pulse together with an accept in the same cycle.
  - Response: `shift_fifo`=0 and `add_item`=1.
  - Next cycle `err_underflow`=1 and `outstanding`=1.
- **Handshake violations.**
  - Sequence: req without gnt at cycles 1–2 with payload changed at 2; req dropped at 3.
  - Response: `err_req_unstable`=1 at 3 and `err_req_drop`=1 at 4. `outstanding` stays 0.
- **Async reset mid-operation.** `outstanding`=2 and `err_overflow`=1, then `rst_ni` pulled low between clock edges.
  - Response: all outputs return to reset values immediately.
  - The first accept after release gives `outstanding`=1.
